tinyalu_issuer: RTL and testbench
=================================

# tinyalu_issuer

RTL command issuer that sits directly upstream of the TinyALU DUT. It accepts ALU commands on a valid/ready stream, buffers them in a small FIFO, and drives the ALU pin-level protocol (op/A/B/start, hold until done, reset sequencing). It returns one response per result-bearing command on a valid/ready stream. It replaces testbench-driven pin wiggling when the ALU is embedded in a larger RTL design.

## Interface
- DATA_W, 9: operand width.
- RES_W, 18: result width, always 2*DATA_W.
- DEPTH, 4: command FIFO entries, power of two, ≥2.
- TIMEOUT, 16: watchdog limit in cycles; used only under the timeout macro.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_a, cmd_b  in  DATA_W  operands.
- cmd_op  in  3  operation_t code.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  RES_W  captured ALU result.
- rsp_op  out  3  op that produced it.
- rsp_err  out  1  watchdog abort flag; constant 0 without the macro.
- alu_start  out  1  ALU start.
- alu_op  out  3  ALU op.
- alu_a, alu_b  out  DATA_W  ALU operands.
- alu_reset_n  out  1  ALU reset, active-low.
- alu_done  in  1  ALU done.
- alu_result  in  RES_W  ALU result.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.

## Operation
- Op codes: no_op=000, add_op=001, and_op=010, xor_op=011, mul_op=100, rst_op=111. The codes 101 and 110 are treated as no_op.
- FIFO push occurs on cmd_valid && cmd_ready.
  - cmd_ready = (count < DEPTH), registered from count.
  - A full FIFO does not accept a push in the same cycle as a pop.
- FSM states are IDLE, WAIT_DONE, PULSE, ALU_RST and RESP.
- IDLE with the FIFO non-empty pops one entry and registers alu_op, alu_a and alu_b.
  - add/and/xor/mul: alu_start=1, go to WAIT_DONE.
  - no_op or unknown code: alu_start=1, go to PULSE.
  - rst_op: alu_start=0, alu_reset_n=0, 2-cycle counter, go to ALU_RST.
- WAIT_DONE:
  - alu_start, alu_op, alu_a and alu_b are held stable.
  - When alu_done=1 is sampled: capture alu_result into rsp_result and cmd op into rsp_op, set alu_start=0 and rsp_valid=1, go to RESP.
- PULSE: alu_start=0, return to IDLE. No response is produced.
- ALU_RST:
  - alu_reset_n stays 0 for exactly 2 cycles, then goes to 1.
  - Returns to IDLE. No response is produced.
- RESP: rsp_valid and the rsp_* fields are held until rsp_ready=1. The cycle after the handshake is IDLE, with rsp_valid=0.
- alu_done seen outside WAIT_DONE is ignored.
- Reset mid-operation: the FIFO is flushed and the FSM returns to IDLE. Any pending response is discarded.

## Timing
- Reset values:
  - cmd_ready=0 while reset is high, then 1 on the first cycle after.
  - rsp_valid=0, rsp_result=0, rsp_op=0, rsp_err=0.
  - alu_start=0, alu_op=0, alu_a=0, alu_b=0, busy=0.
  - alu_reset_n=0 during reset and for 1 cycle after it deasserts.
- Accepting into an empty idle block: accept at cycle 0, pop at cycle 1, alu_start=1 at cycle 2.
- Response latency: rsp_valid rises the cycle after alu_done is sampled high.
- Issue rate: at most one command is in flight. The next pop happens in the IDLE cycle that follows RESP, PULSE or ALU_RST.
- FIFO pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Configuration
- Macro: TINYALU_ISSUER_TIMEOUT_EN.
- Defined:
  - WAIT_DONE counts cycles.
  - If alu_done has not been seen after TIMEOUT cycles: alu_start=0, rsp_result=0, rsp_err=1, go to RESP.
  - The counter clears on every pop.
- Undefined: no counter is built, rsp_err is tied to 0, and WAIT_DONE waits indefinitely.

## Structure
- tinyalu_pkg gains:
  - the op-code constants and operation_t (3-bit enum including rst_op);
  - the issuer_state_t enum;
  - a packed cmd_t struct {op, a, b}.
- Sub-module tinyalu_cmd_fifo: synchronous FIFO of cmd_t with push, pop, full, empty and count. It uses the same clk and reset.

## Test plan
- add 0x0FF + 0x001 with the ALU model giving done one cycle after start → rsp_result=0x00100, rsp_op=001, alu_start high for exactly 2 cycles.
- mul 0x1FF * 0x1FF with done after 3 cycles → rsp_result=0x3FC01, operands stable throughout WAIT_DONE.
- Push 5 commands while holding rsp_ready=0 (DEPTH=4) → cmd_ready drops after 4 accepted plus 1 popped. All 5 responses arrive in order once rsp_ready=1.
- no_op then rst_op then xor 0x0AA ^ 0x055:
  - no_op gives a 1-cycle start pulse and no response;
  - rst_op gives alu_reset_n low 2 cycles and no response;
  - xor gives rsp_result=0x000FF.
- Assert reset while in WAIT_DONE with 2 entries queued → next cycle alu_start=0, FIFO empty, rsp_valid=0, busy=0.
- With the macro defined, TIMEOUT=16 and alu_done held 0 → rsp_valid rises with rsp_err=1 and rsp_result=0 after 16 WAIT_DONE cycles, and the next command issues normally.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// -----------------------------------------------------------------------------
// tinyalu_pkg
// Shared types for the TinyALU command issuer:
//   - DATA_W / RES_W   : operand and result widths (RES_W = 2*DATA_W)
//   - FIFO_DEPTH       : default command FIFO depth
//   - operation_t      : 3-bit ALU op codes (101/110 are decoded as no_op)
//   - issuer_state_t   : issuer FSM states
//   - cmd_t            : packed command {op, a, b} stored in the FIFO
//   - decode_op()      : maps a raw 3-bit code onto a legal operation_t
// -----------------------------------------------------------------------------
package tinyalu_pkg;

    localparam int DATA_W     = 9;
    localparam int RES_W      = 2 * DATA_W;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DONE = 3'd1,
        PULSE     = 3'd2,
        ALU_RST   = 3'd3,
        RESP      = 3'd4
    } issuer_state_t;

    // The raw code is kept in the FIFO so that an unknown code is only
    // interpreted once, at issue time.
    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    // Unused encodings fall back to no_op so the ALU never sees them.
    function automatic operation_t decode_op(input logic [2:0] code);
        operation_t op;
        case (code)
            3'b001:  op = add_op;
            3'b010:  op = and_op;
            3'b011:  op = xor_op;
            3'b100:  op = mul_op;
            3'b111:  op = rst_op;
            default: op = no_op;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/tinyalu_issuer_if.sv
// -----------------------------------------------------------------------------
// tinyalu_issuer_if
// Bundles the three handshakes of the issuer:
//   cmd_*  : command stream in   (cmd_valid/cmd_ready, cmd_op, cmd_a, cmd_b)
//   rsp_*  : response stream out (rsp_valid/rsp_ready, rsp_result, rsp_op, rsp_err)
//   alu_*  : TinyALU pin interface (start/op/a/b/reset_n out, done/result in)
// Modports: master = issuer side, slave = environment (producer/consumer/ALU).
// -----------------------------------------------------------------------------
interface tinyalu_issuer_if;
    import tinyalu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [2:0]        cmd_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_result;
    logic [2:0]        rsp_op;
    logic              rsp_err;

    logic              alu_start;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_reset_n;
    logic              alu_done;
    logic [RES_W-1:0]  alu_result;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
        output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err,
               alu_start, alu_op, alu_a, alu_b, alu_reset_n
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
        input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err,
               alu_start, alu_op, alu_a, alu_b, alu_reset_n
    );
endinterface

// File: rtl/tinyalu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tinyalu_cmd_fifo
// Synchronous FIFO of cmd_t, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, reset      : clock, synchronous active-high reset (flushes contents)
//   i_push, i_din   : write request and data (ignored when full)
//   i_pop           : read request (ignored when empty)
//   o_dout          : head entry, valid whenever o_empty is low
//   o_full, o_empty : status
//   o_count         : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module tinyalu_cmd_fifo
    import tinyalu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  cmd_t                   i_din,
    input  logic                   i_pop,
    output cmd_t                   o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == CW'(0));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end
endmodule

// File: rtl/tinyalu_issuer.sv
// -----------------------------------------------------------------------------
// tinyalu_issuer
// Accepts ALU commands, queues them, drives the TinyALU pin protocol one
// command at a time and returns one response per result-bearing command.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (flushes queue, drops response)
//   bus    : tinyalu_issuer_if.master (cmd_*, rsp_*, alu_* signals)
//   busy   : FSM not idle or queue non-empty
// Optional feature: define TINYALU_ISSUER_TIMEOUT_EN to add a watchdog that
// aborts WAIT_DONE after TIMEOUT cycles with rsp_err=1 and rsp_result=0.
// Without it rsp_err is constant 0 and WAIT_DONE waits indefinitely.
// -----------------------------------------------------------------------------
module tinyalu_issuer
    import tinyalu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
`ifdef TINYALU_ISSUER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    tinyalu_issuer_if.master bus,
    output logic             busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    cmd_t              w_fifo_din;
    cmd_t              w_fifo_dout;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_next;
    operation_t        w_pop_op;

    issuer_state_t     r_state;
    logic              r_cmd_ready;
    logic              r_alu_start;
    logic              r_alu_reset_n;
    logic [2:0]        r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_rsp_valid;
    logic [RES_W-1:0]  r_rsp_result;
    logic [2:0]        r_rsp_op;
    logic              r_rst_cnt;
    logic              r_post_rst;

    assign w_fifo_din.op = bus.cmd_op;
    assign w_fifo_din.a  = bus.cmd_a;
    assign w_fifo_din.b  = bus.cmd_b;
    assign w_push        = bus.cmd_valid & r_cmd_ready & ~w_full;
    assign w_pop         = (r_state == IDLE) & ~w_empty;
    assign w_pop_op      = decode_op(w_fifo_dout.op);
    assign w_count_next  = w_count + CW'(w_push) - CW'(w_pop);

    tinyalu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // cmd_ready registered from the next occupancy so it always matches count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_ready <= 1'b0;
        end else begin
            r_cmd_ready <= (w_count_next < CW'(DEPTH));
        end
    end

`ifdef TINYALU_ISSUER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] r_wd_cnt;
    logic          r_rsp_err;
`endif

    // Issue FSM with registered ALU pins and response fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_alu_start   <= 1'b0;
            r_alu_reset_n <= 1'b0;
            r_alu_op      <= 3'b000;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_op      <= 3'b000;
            r_rst_cnt     <= 1'b0;
            r_post_rst    <= 1'b1;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
            r_wd_cnt      <= '0;
            r_rsp_err     <= 1'b0;
`endif
        end else begin
            r_post_rst <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Keeps the ALU in reset for one extra cycle after our own reset.
                    r_alu_reset_n <= ~r_post_rst;
                    r_alu_start   <= 1'b0;
                    if (w_pop) begin
                        r_alu_op <= w_pop_op;
                        r_alu_a  <= w_fifo_dout.a;
                        r_alu_b  <= w_fifo_dout.b;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
                        r_wd_cnt <= '0;
`endif
                        case (w_pop_op)
                            rst_op: begin
                                r_alu_reset_n <= 1'b0;
                                r_rst_cnt     <= 1'b0;
                                r_state       <= ALU_RST;
                            end
                            add_op, and_op, xor_op, mul_op: begin
                                r_alu_start <= 1'b1;
                                r_state     <= WAIT_DONE;
                            end
                            default: begin
                                r_alu_start <= 1'b1;
                                r_state     <= PULSE;
                            end
                        endcase
                    end
                end
                WAIT_DONE: begin
                    if (bus.alu_done) begin
                        r_rsp_result <= bus.alu_result;
                        r_rsp_op     <= r_alu_op;
                        r_alu_start  <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
                        r_rsp_err    <= 1'b0;
                    end else if (r_wd_cnt == TW'(TIMEOUT - 1)) begin
                        r_rsp_result <= '0;
                        r_rsp_op     <= r_alu_op;
                        r_alu_start  <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_err    <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + TW'(1);
`endif
                    end
                end
                PULSE: begin
                    r_alu_start <= 1'b0;
                    r_state     <= IDLE;
                end
                ALU_RST: begin
                    // Second cycle of the ALU reset window releases it.
                    if (r_rst_cnt) begin
                        r_alu_reset_n <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_rst_cnt <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_alu_start <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

`ifdef TINYALU_ISSUER_TIMEOUT_EN
    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_op      = r_rsp_op;
    assign bus.alu_start   = r_alu_start;
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_reset_n = r_alu_reset_n;
    assign busy            = (r_state != IDLE) | ~w_empty;
endmodule

// File: tb/tb_tinyalu_issuer.sv
// -----------------------------------------------------------------------------
// tb_tinyalu_issuer
// Directed bench for tinyalu_issuer with a behavioural TinyALU responder
// whose done latency (cycles after start) is set by alu_lat (0 = never).
// -----------------------------------------------------------------------------
module tb_tinyalu_issuer;
    logic clk = 1'b0;
    logic reset;
    logic busy;

    int checks   = 0;
    int failures = 0;
    int alu_lat  = 1;
    int alu_cnt  = 0;

    int start_cycles    = 0;
    int rstn_low_cycles = 0;
    int rsp_cycles      = 0;
    int unstable        = 0;
    logic       prev_start = 1'b0;
    logic [2:0] prev_op    = 3'b000;
    logic [8:0] prev_a     = 9'h000;
    logic [8:0] prev_b     = 9'h000;

    tinyalu_issuer_if bus ();

    tinyalu_issuer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] alu_model(input logic [2:0] op, input logic [8:0] a, input logic [8:0] b);
        case (op)
            3'b001:  return {9'h000, a} + {9'h000, b};
            3'b010:  return {9'h000, a & b};
            3'b011:  return {9'h000, a ^ b};
            3'b100:  return {9'h000, a} * {9'h000, b};
            default: return 18'h00000;
        endcase
    endfunction

    // TinyALU responder: done pulses alu_lat cycles after start is first seen.
    always @(posedge clk) begin
        if (reset || bus.alu_start !== 1'b1) begin
            alu_cnt        <= 0;
            bus.alu_done   <= 1'b0;
            bus.alu_result <= 18'h00000;
        end else if (bus.alu_done) begin
            bus.alu_done <= 1'b0;
        end else if (alu_lat > 0 && alu_cnt + 1 == alu_lat) begin
            bus.alu_done   <= 1'b1;
            bus.alu_result <= alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
            alu_cnt        <= alu_cnt + 1;
        end else begin
            alu_cnt <= alu_cnt + 1;
        end
    end

    // Cycle counters for start, ALU reset window, response valid and operand stability.
    always @(posedge clk) begin
        if (bus.alu_start === 1'b1) start_cycles <= start_cycles + 1;
        if (bus.alu_reset_n === 1'b0 && reset === 1'b0) rstn_low_cycles <= rstn_low_cycles + 1;
        if (bus.rsp_valid === 1'b1) rsp_cycles <= rsp_cycles + 1;
        if (bus.alu_start === 1'b1 && prev_start &&
            (bus.alu_a !== prev_a || bus.alu_b !== prev_b || bus.alu_op !== prev_op))
            unstable <= unstable + 1;
        prev_start <= (bus.alu_start === 1'b1);
        prev_op    <= bus.alu_op;
        prev_a     <= bus.alu_a;
        prev_b     <= bus.alu_b;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [8:0] a, input logic [8:0] b);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 100) check("send_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [17:0] exp_res, input logic [2:0] exp_op, input logic exp_err);
        int n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        check({tag, "_valid"},  {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, "_result"}, {14'd0, bus.rsp_result}, {14'd0, exp_res});
        check({tag, "_op"},     {29'd0, bus.rsp_op}, {29'd0, exp_op});
        check({tag, "_err"},    {31'd0, bus.rsp_err}, {31'd0, exp_err});
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int r0;
        int v0;
        int u0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_a     = 9'h000;
        bus.cmd_b     = 9'h000;
        bus.rsp_ready = 1'b0;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_cmd_ready",  {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_rsp_valid",  {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_result", {14'd0, bus.rsp_result}, 32'd0);
        check("rst_rsp_op",     {29'd0, bus.rsp_op}, 32'd0);
        check("rst_rsp_err",    {31'd0, bus.rsp_err}, 32'd0);
        check("rst_alu_start",  {31'd0, bus.alu_start}, 32'd0);
        check("rst_alu_op",     {29'd0, bus.alu_op}, 32'd0);
        check("rst_alu_ab",     {14'd0, bus.alu_a, bus.alu_b}, 32'd0);
        check("rst_alu_rstn",   {31'd0, bus.alu_reset_n}, 32'd0);
        check("rst_busy",       {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("post_rst_rstn_low",  {31'd0, bus.alu_reset_n}, 32'd0);
        @(negedge clk);
        check("post_rst_rstn_high", {31'd0, bus.alu_reset_n}, 32'd1);

        // add 0x0FF + 0x001, done one cycle after start; exact cycle timing.
        alu_lat = 1;
        s0 = start_cycles;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b001;
        bus.cmd_a     = 9'h0FF;
        bus.cmd_b     = 9'h001;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("add_c1_start", {31'd0, bus.alu_start}, 32'd0);
        check("add_c1_busy",  {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("add_c2_start", {31'd0, bus.alu_start}, 32'd1);
        check("add_c2_op",    {29'd0, bus.alu_op}, 32'd1);
        check("add_c2_ab",    {14'd0, bus.alu_a, bus.alu_b}, {14'd0, 9'h0FF, 9'h001});
        @(negedge clk);
        check("add_c3_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check("add_c4_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("add_result",       {14'd0, bus.rsp_result}, 32'h00100);
        check("add_rsp_op",       {29'd0, bus.rsp_op}, 32'd1);
        check("add_c4_start",     {31'd0, bus.alu_start}, 32'd0);
        check("add_start_cycles", start_cycles - s0, 32'd2);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("add_after_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("add_after_hs_busy",  {31'd0, busy}, 32'd0);

        // mul 0x1FF * 0x1FF with done three cycles after start.
        alu_lat = 3;
        s0 = start_cycles;
        u0 = unstable;
        send(3'b100, 9'h1FF, 9'h1FF);
        wait_rsp("mul", 18'h3FC01, 3'b100, 1'b0);
        check("mul_start_cycles", start_cycles - s0, 32'd4);
        check("mul_operands_stable", unstable - u0, 32'd0);

        // Five commands with rsp_ready low: four queued plus one in flight.
        alu_lat = 1;
        send(3'b001, 9'h001, 9'h002);
        send(3'b011, 9'h00F, 9'h0FF);
        send(3'b010, 9'h1F0, 9'h0FF);
        send(3'b100, 9'h003, 9'h005);
        send(3'b001, 9'h1FF, 9'h1FF);
        check("fill_cmd_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("fill_cmd_ready_held", {31'd0, bus.cmd_ready}, 32'd0);
        check("fill_busy", {31'd0, busy}, 32'd1);
        wait_rsp("fill0", 18'h00003, 3'b001, 1'b0);
        wait_rsp("fill1", 18'h000F0, 3'b011, 1'b0);
        wait_rsp("fill2", 18'h000F0, 3'b010, 1'b0);
        wait_rsp("fill3", 18'h0000F, 3'b100, 1'b0);
        wait_rsp("fill4", 18'h003FE, 3'b001, 1'b0);

        // no_op, rst_op, xor: only the xor produces a response.
        s0 = start_cycles;
        r0 = rstn_low_cycles;
        v0 = rsp_cycles;
        send(3'b000, 9'h011, 9'h022);
        send(3'b111, 9'h000, 9'h000);
        send(3'b011, 9'h0AA, 9'h055);
        wait_rsp("xor", 18'h000FF, 3'b011, 1'b0);
        check("seq_start_cycles", start_cycles - s0, 32'd3);
        check("seq_rstn_low",     rstn_low_cycles - r0, 32'd2);
        check("seq_rsp_cycles",   rsp_cycles - v0, 32'd1);
        check("seq_rstn_final",   {31'd0, bus.alu_reset_n}, 32'd1);

        // Reset while WAIT_DONE with two commands queued.
        alu_lat = 0;
        send(3'b001, 9'h001, 9'h001);
        send(3'b001, 9'h002, 9'h002);
        send(3'b001, 9'h003, 9'h003);
        check("midrst_in_flight", {31'd0, bus.alu_start}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_start",     {31'd0, bus.alu_start}, 32'd0);
        check("midrst_busy",      {31'd0, busy}, 32'd0);
        check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_idle_busy", {31'd0, busy}, 32'd0);
        alu_lat = 1;
        send(3'b001, 9'h010, 9'h020);
        wait_rsp("midrst_next", 18'h00030, 3'b001, 1'b0);

`ifdef TINYALU_ISSUER_TIMEOUT_EN
        // Watchdog abort after 16 WAIT_DONE cycles, then a normal command.
        alu_lat = 0;
        s0 = start_cycles;
        send(3'b100, 9'h002, 9'h003);
        wait_rsp("timeout", 18'h00000, 3'b100, 1'b1);
        check("timeout_wait_cycles", start_cycles - s0, 32'd16);
        alu_lat = 1;
        send(3'b001, 9'h002, 9'h002);
        wait_rsp("after_timeout", 18'h00004, 3'b001, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
